// File: rtl/frame_ctrl_pkg.sv
// rtl/frame_ctrl_pkg.sv - shared state encoding and default sizes for the frame swap controller
package frame_ctrl_pkg;

    typedef enum logic [1:0] {
        DRAW      = 2'd0,
        WAIT_SYNC = 2'd1,
        SWAP      = 2'd2,
        CLEAR     = 2'd3
    } frame_state_e;

    localparam int unsigned DEF_A            = 9;
    localparam int unsigned DEF_S            = 24;
    localparam int unsigned DEF_CLEAR_CYCLES = 2;
    localparam int unsigned DEF_C            = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with a single pointer register
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] elig_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    // Pick a winner; the pointer always moves to the requester that lost (or was absent).
    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (elig_i == 2'b11) begin
            gnt_o[ptr_q] = 1'b1;
            ptr_d        = ~ptr_q;
        end else if (elig_i[0]) begin
            gnt_o = 2'b01;
            ptr_d = 1'b1;
        end else if (elig_i[1]) begin
            gnt_o = 2'b10;
            ptr_d = 1'b0;
        end
    end

    // Pointer register; requester 0 has priority out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/frame_swap_controller.sv
// rtl/frame_swap_controller.sv - write arbitration and frame-boundary buffer swap sequencing
module frame_swap_controller
    import frame_ctrl_pkg::*;
#(
    parameter int unsigned A            = DEF_A,
    parameter int unsigned S            = DEF_S,
    parameter int unsigned CLEAR_CYCLES = DEF_CLEAR_CYCLES,
    parameter int unsigned C            = DEF_C
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         frame_start,
    input  logic         req0,
    input  logic [A-1:0] addr0,
    input  logic [S-1:0] data0,
    input  logic         done0,
    output logic         gnt0,
    input  logic         req1,
    input  logic [A-1:0] addr1,
    input  logic [S-1:0] data1,
    input  logic         done1,
    output logic         gnt1,
    output logic [A-1:0] mem_address_write,
    output logic [S-1:0] mem_data_write,
    output logic         mem_wren,
    output logic         mem_swap,
    output logic         frame_go,
    output logic         overrun,
    output logic [C-1:0] frame_count
);

    localparam logic [7:0] CLR_LAST = 8'(CLEAR_CYCLES - 1);

    frame_state_e  state_q, state_d;
    logic [1:0]    latch_q, latch_d;
    logic [7:0]    clr_cnt_q, clr_cnt_d;
    logic [C-1:0]  frame_count_q, frame_count_d;
    logic          frame_go_q, frame_go_d;
    logic          mem_wren_q, mem_wren_d;
    logic [A-1:0]  mem_addr_q, mem_addr_d;
    logic [S-1:0]  mem_data_q, mem_data_d;
    logic [1:0]    elig;
    logic [1:0]    gnt;
    logic          all_done;

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .elig_i  (elig),
        .gnt_o   (gnt)
    );

    assign gnt0              = gnt[0];
    assign gnt1              = gnt[1];
    assign mem_wren          = mem_wren_q;
    assign mem_address_write = mem_addr_q;
    assign mem_data_write    = mem_data_q;
    assign frame_go          = frame_go_q;
    assign frame_count       = frame_count_q;

    // Frame sequencing: next state, done latches, clear countdown and the swap/overrun pulses.
    always_comb begin
        state_d       = state_q;
        latch_d       = latch_q;
        clr_cnt_d     = clr_cnt_q;
        frame_count_d = frame_count_q;
        frame_go_d    = 1'b0;
        elig          = 2'b00;
        overrun       = 1'b0;
        mem_swap      = 1'b0;
        // A done pulse arriving this cycle counts as finished, so a same-cycle vblank still swaps.
        all_done      = (latch_q[0] | done0) & (latch_q[1] | done1);

        case (state_q)
            DRAW: begin
                // Eligibility uses the registered latch so a request alongside its done pulse is still served.
                elig    = {req1 & ~latch_q[1], req0 & ~latch_q[0]};
                latch_d = latch_q | {done1, done0};
                if (frame_start) begin
                    if (all_done) begin
                        state_d = SWAP;
                    end else begin
                        overrun = 1'b1;
                    end
                end else if (all_done) begin
                    state_d = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                if (frame_start) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                mem_swap      = 1'b1;
                frame_count_d = frame_count_q + 1'b1;
                clr_cnt_d     = '0;
                state_d       = CLEAR;
            end
            CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d    = DRAW;
                    latch_d    = 2'b00;
                    frame_go_d = 1'b1;
                    clr_cnt_d  = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DRAW;
            end
        endcase
    end

    // Memory write stage: capture the granted requester; address and data hold when idle.
    always_comb begin
        mem_wren_d = |gnt;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (gnt[0]) begin
            mem_addr_d = addr0;
            mem_data_d = data0;
        end else if (gnt[1]) begin
            mem_addr_d = addr1;
            mem_data_d = data1;
        end
    end

    // State and output registers; reset aborts any frame in progress immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= DRAW;
            latch_q       <= 2'b00;
            clr_cnt_q     <= '0;
            frame_count_q <= '0;
            frame_go_q    <= 1'b0;
            mem_wren_q    <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            latch_q       <= latch_d;
            clr_cnt_q     <= clr_cnt_d;
            frame_count_q <= frame_count_d;
            frame_go_q    <= frame_go_d;
            mem_wren_q    <= mem_wren_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
        end
    end

endmodule

// File: tb/tb_frame_swap_controller.sv
// tb/tb_frame_swap_controller.sv - scoreboard bench for frame_swap_controller
module tb_frame_swap_controller;

    localparam int A   = 9;
    localparam int S   = 24;
    localparam int CLR = 2;
    localparam int C   = 16;

    localparam int K_GNT  = 0;
    localparam int K_WR   = 1;
    localparam int K_SWAP = 2;
    localparam int K_GO   = 3;
    localparam int K_OVR  = 4;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         frame_start = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0, done0 = 1'b0, done1 = 1'b0;
    logic [A-1:0] addr0 = '0, addr1 = '0;
    logic [S-1:0] data0 = '0, data1 = '0;
    logic         gnt0, gnt1, mem_wren, mem_swap, frame_go, overrun;
    logic [A-1:0] mem_address_write;
    logic [S-1:0] mem_data_write;
    logic [C-1:0] frame_count;

    frame_swap_controller #(.A(A), .S(S), .CLEAR_CYCLES(CLR), .C(C)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .frame_start       (frame_start),
        .req0              (req0),
        .addr0             (addr0),
        .data0             (data0),
        .done0             (done0),
        .gnt0              (gnt0),
        .req1              (req1),
        .addr1             (addr1),
        .data1             (data1),
        .done1             (done1),
        .gnt1              (gnt1),
        .mem_address_write (mem_address_write),
        .mem_data_write    (mem_data_write),
        .mem_wren          (mem_wren),
        .mem_swap          (mem_swap),
        .frame_go          (frame_go),
        .overrun           (overrun),
        .frame_count       (frame_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        int           v;
        logic [A-1:0] addr;
        logic [S-1:0] data;
    } ev_t;

    ev_t   evq [5][$];
    string nm [5] = '{"grant", "write", "swap", "frame_go", "overrun"};
    int    checks = 0;
    int    errors = 0;

    // Reference model: which phase of the frame we are in, who has finished, who wins a tie.
    int m_phase;       // 0 drawing, 1 waiting for vblank, 2 swapping, 3 clearing
    int m_clear_left;
    bit m_fin0, m_fin1;
    int m_pref;
    int m_frames;
    bit m_go_next;
    bit hold0, hold1;

    function automatic void push(input int k, input int c, input int v,
                                 input logic [A-1:0] a, input logic [S-1:0] d);
        ev_t e;
        e.cyc = c; e.v = v; e.addr = a; e.data = d;
        evq[k].push_back(e);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_clear_left = 0; m_fin0 = 0; m_fin1 = 0;
        m_pref = 0; m_frames = 0; m_go_next = 0; hold0 = 0; hold1 = 0;
        for (int k = 0; k < 5; k++) evq[k].delete();
    endtask

    task automatic model_step(output int win);
        bit e0, e1, f0, f1;
        win = -1;
        if (m_go_next) begin
            push(K_GO, cyc, m_frames, '0, '0);
            m_go_next = 0;
        end
        case (m_phase)
            0: begin
                e0 = req0 && !m_fin0;
                e1 = req1 && !m_fin1;
                if (e0 && e1) win = m_pref;
                else if (e0)  win = 0;
                else if (e1)  win = 1;
                if (win == 0) push(K_WR, cyc + 1, 0, addr0, data0);
                if (win == 1) push(K_WR, cyc + 1, 0, addr1, data1);
                if (win >= 0) begin
                    push(K_GNT, cyc, win, '0, '0);
                    m_pref = 1 - win;
                end
                f0 = m_fin0 || done0;
                f1 = m_fin1 || done1;
                if (frame_start && f0 && f1) m_phase = 2;
                else if (frame_start)        push(K_OVR, cyc, 0, '0, '0);
                else if (f0 && f1)           m_phase = 1;
                m_fin0 = f0;
                m_fin1 = f1;
            end
            1: if (frame_start) m_phase = 2;
            2: begin
                push(K_SWAP, cyc, m_frames, '0, '0);
                m_frames     = (m_frames + 1) % (1 << C);
                m_clear_left = CLR;
                m_phase      = 3;
            end
            default: begin
                m_clear_left--;
                if (m_clear_left == 0) begin
                    m_phase = 0; m_fin0 = 0; m_fin1 = 0; m_go_next = 1;
                end
            end
        endcase
    endtask

    // One clock of stimulus; a pending request is kept asserted until the model grants it.
    task automatic step(input bit fs, input bit r0, input bit r1, input bit d0, input bit d1);
        int  win;
        bit  q0, q1;
        @(posedge clock);
        #1;
        q0 = r0 || hold0;
        q1 = r1 || hold1;
        if (q0 && !hold0) begin addr0 = A'($urandom); data0 = S'($urandom); end
        if (q1 && !hold1) begin addr1 = A'($urandom); data1 = S'($urandom); end
        req0 = q0; req1 = q1; frame_start = fs; done0 = d0; done1 = d1;
        model_step(win);
        hold0 = q0 && (win != 0);
        hold1 = q1 && (win != 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: whenever the DUT presents an event, or one is due, pop and compare.
    bit  pres [5];
    int  act  [5];
    ev_t me;
    always @(negedge clock) begin
        if (reset_n) begin
            pres[K_GNT]  = gnt0 || gnt1;  act[K_GNT]  = (gnt0 && gnt1) ? 2 : (gnt1 ? 1 : 0);
            pres[K_WR]   = mem_wren;      act[K_WR]   = 0;
            pres[K_SWAP] = mem_swap;      act[K_SWAP] = int'(frame_count);
            pres[K_GO]   = frame_go;      act[K_GO]   = int'(frame_count);
            pres[K_OVR]  = overrun;       act[K_OVR]  = 0;
            for (int k = 0; k < 5; k++) begin
                if (pres[k] || (evq[k].size() > 0 && evq[k][0].cyc <= cyc)) begin
                    checks++;
                    if (evq[k].size() == 0 || evq[k][0].cyc > cyc) begin
                        errors++;
                        $display("FAIL %s unexpected at cycle %0d: got value %0d, none expected", nm[k], cyc, act[k]);
                    end else begin
                        me = evq[k].pop_front();
                        if (!pres[k] || me.cyc != cyc) begin
                            errors++;
                            $display("FAIL %s missing: expected at cycle %0d, got present=%0d at cycle %0d", nm[k], me.cyc, pres[k], cyc);
                        end else if (act[k] != me.v ||
                                     (k == K_WR && (mem_address_write != me.addr || mem_data_write != me.data))) begin
                            errors++;
                            $display("FAIL %s value at cycle %0d: got %0d addr %h data %h, expected %0d addr %h data %h",
                                     nm[k], cyc, act[k], mem_address_write, mem_data_write, me.v, me.addr, me.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        chk("reset_wren", mem_wren, 0);
        chk("reset_swap", mem_swap, 0);
        chk("reset_go", frame_go, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_count", int'(frame_count), 0);
        chk("reset_addr", int'(mem_address_write), 0);
        chk("reset_data", int'(mem_data_write), 0);
        @(negedge clock) reset_n = 1'b1;

        // Contention: both requesters held, grants alternate starting with requester 0.
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
        idle(4);

        // Normal frame: done0, done1 ten cycles later, vblank ten cycles after that.
        step(0, 0, 0, 1, 0); idle(9);
        step(0, 0, 0, 0, 1); idle(9);
        step(1, 0, 0, 0, 0); idle(6);

        // Overrun, then a completed frame on the following vblank.
        step(0, 0, 0, 1, 0); idle(3);
        step(1, 0, 0, 0, 0); idle(2);
        step(0, 0, 0, 0, 1); idle(3);
        step(1, 0, 0, 0, 0); idle(6);

        // Same-cycle finish: done1 and vblank together.
        step(0, 0, 0, 1, 0); idle(3);
        step(1, 0, 0, 0, 1); idle(6);

        // Post-done exclusion: requester 0 keeps asking after finishing.
        step(0, 1, 1, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 1);
        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);
        idle(4);

        // Randomized traffic, vblanks and done pulses.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
        end

        // Drive to a swap, then reset while the back buffer is clearing.
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 1, 1);
            if (m_phase == 3) break;
        end
        chk("reached_clear", m_phase, 3);
        @(posedge clock);
        #3;
        req0 = 0; req1 = 0; frame_start = 0; done0 = 0; done1 = 0;
        model_reset();
        reset_n = 1'b0;
        #1;
        chk("abort_swap", mem_swap, 0);
        chk("abort_wren", mem_wren, 0);
        chk("abort_go", frame_go, 0);
        chk("abort_count", int'(frame_count), 0);
        chk("abort_addr", int'(mem_address_write), 0);
        chk("abort_data", int'(mem_data_write), 0);
        @(negedge clock) reset_n = 1'b1;
        step(0, 1, 1, 0, 0);
        #2;
        chk("post_reset_gnt0", gnt0, 1);
        step(0, 1, 1, 0, 0);
        idle(4);

        for (int k = 0; k < 5; k++) chk({nm[k], "_left_over"}, evq[k].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
